cm_merge: RTL and testbench
===========================

Name: cm_merge

Overview:
- Streaming two-way merger. Takes two independently sorted input streams (e.g. successive outputs of the parallel sorter, serialized) and emits one ascending sorted stream per frame.
- Sits downstream of the sorting network, so wide data sets can be sorted as chunks and then merged.
- Valid/ready handshakes on all ports; one element per cycle sustained throughput.

Parameters:
- DWIDTH, 8, element width in bits; unsigned compare.
- CHK_ORDER, 1, when 1 instantiates the input order checker that drives o_err; when 0 o_err is tied 0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_a_vld  in  1  stream A element valid
- o_a_rdy  out  1  stream A element accepted when i_a_vld & o_a_rdy
- i_a_data  in  DWIDTH  stream A element
- i_a_last  in  1  last element of stream A in the current frame
- i_b_vld  in  1  stream B element valid
- o_b_rdy  out  1  stream B ready
- i_b_data  in  DWIDTH  stream B element
- i_b_last  in  1  last element of stream B in the current frame
- o_vld  out  1  output element valid
- i_rdy  in  1  downstream ready
- o_data  out  DWIDTH  merged element
- o_last  out  1  last element of the merged frame
- o_src  out  1  source of o_data: 0 = A, 1 = B
- o_err  out  1  one-cycle pulse: an accepted input element is smaller than the previous element of the same stream in the same frame

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_rst) is asynchronous and active-high.
- Reset values: o_vld=0, o_data=0, o_last=0, o_src=0, o_err=0, o_a_rdy=0, o_b_rdy=0; state=ST_MERGE; order-check history cleared.
- Frame: one sorted sequence on A terminated by i_a_last plus one on B terminated by i_b_last. Each stream has at least one element per frame.
- Output register: single stage. It loads when empty or when i_rdy=1 (load_en = !o_vld | i_rdy).
- Latency: 1 cycle from input acceptance to o_vld.
- Back-pressure: with continuous i_rdy=1, the block sustains 1 element per cycle.
- ST_MERGE, both streams open:
  - Selection waits until both i_a_vld and i_b_vld are 1. It never emits one side without comparing against the other.
  - If a_data <= b_data, pick A; else pick B. Ties go to A (stable merge).
  - o_x_rdy is asserted only for the picked side, and only when load_en=1.
  - Picked A with i_a_last=1 -> ST_DRAIN_B. Picked B with i_b_last=1 -> ST_DRAIN_A.
- ST_DRAIN_A (B finished):
  - Forward A unconditionally. o_a_rdy=load_en and o_b_rdy=0.
  - On accepted A element with i_a_last=1: o_last=1 on that element, then -> ST_MERGE.
- ST_DRAIN_B: symmetric to ST_DRAIN_A, with A and B swapped.
- o_last is set only in the drain states. The frame's last output is always the final element of the stream that finishes second.
- Both i_a_last and i_b_last at the head of their streams in ST_MERGE: the smaller is emitted without o_last, the drain state emits the other with o_last=1. If equal, A goes first.
- o_src, o_data and o_last are registered together with o_vld. They are held stable while o_vld=1 and i_rdy=0 (AXI-style hold rule).
- Inputs must also be held stable while vld=1 and rdy=0. The block does not depend on this for correctness of its own state.
- Order checker:
  - Per stream, store the last accepted value plus a "have_prev" bit. have_prev is cleared after accepting that stream's last element.
  - o_err pulses 1 cycle after the offending acceptance.
  - Data is still forwarded; the output may then be unsorted, which is the documented consequence.
- Reset mid-frame: asynchronous clear of state, output register and history. The partial frame is discarded and the next accepted elements start a new frame.
- No deadlock: the block never asserts rdy on a stream whose element will not be accepted that cycle.

Decomposition:
- Shared package lib_cm cm_pkg_merge:
  - typedef enum t_merge_state {ST_MERGE, ST_DRAIN_A, ST_DRAIN_B}
  - typedef struct t_merge_beat {data, last, src}, used for the output register contents.
- Sub-module cm_pipe_reg (parameterized width, valid/ready single register slice with async active-high reset). It holds t_merge_beat and is reusable by other lib_cm streaming blocks.
- Comparator, select mux, FSM and order checker stay in cm_merge.

Test Plan:
- Basic merge, i_rdy=1: A={1,4,9,last}, B={2,3,10,last} -> o_data=1,2,3,4,9,10, o_src=0,1,1,0,0,1, o_last only on 10, one beat/cycle after first, o_err=0.
- Ties and stability: A={5,5,last}, B={5,last} -> o_src=0,0,1, o_last on the B element.
- Early finish plus back-pressure: A={7,last}, B={1,2,3,8,last}, i_rdy toggling 1,0 -> order 1,2,3,7,8; o_data stable during every i_rdy=0 cycle; o_last on 8; no element lost or duplicated.
- Unsorted input: A={6,2,last}, B={9,last} -> o_err single pulse one cycle after 2 is accepted; output 6,2,9 with o_last on 9.
- Reset mid-frame: assert i_rst asynchronously after two outputs of frame {1,3,5}/{2,4} -> o_vld=0 and both rdys 0 immediately. After release, frame A={8,last}, B={7,last} -> 7,8 with o_last on 8.
- Back-to-back frames: frame1 A={1,last}, B={2,last}, frame2 A={0,last}, B={3,last} -> 1,2(last),0,3(last); o_err=0 because history resets per frame.

Source files
------------

// File: rtl/cm_merge_pkg.sv
// cm_merge_pkg: shared types for the two-way streaming merger.
//   t_merge_state : merge FSM states
//   t_merge_beat  : contents of the output register slice {data, last, src}
package cm_merge_pkg;

  // Element width carried by t_merge_beat; cm_merge's DWIDTH must match it.
  localparam int CM_DWIDTH = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_MERGE,    // both streams open, compare heads
    ST_DRAIN_A,  // B finished, forward rest of A
    ST_DRAIN_B   // A finished, forward rest of B
  } t_merge_state;

  typedef struct packed {
    logic [CM_DWIDTH-1:0] data;
    logic                 last;
    logic                 src;
  } t_merge_beat;

  localparam int CM_BEAT_W = $bits(t_merge_beat);

endpackage

// File: rtl/cm_merge_if.sv
// cm_merge_if: handshake bundle of cm_merge.
//   Stream A : i_a_vld, o_a_rdy, i_a_data, i_a_last
//   Stream B : i_b_vld, o_b_rdy, i_b_data, i_b_last
//   Output   : o_vld, i_rdy, o_data, o_last, o_src, o_err
// slave modport is the merger side, master is the environment side.
interface cm_merge_if #(parameter int DWIDTH = cm_merge_pkg::CM_DWIDTH);

  logic              i_a_vld;
  logic              o_a_rdy;
  logic [DWIDTH-1:0] i_a_data;
  logic              i_a_last;

  logic              i_b_vld;
  logic              o_b_rdy;
  logic [DWIDTH-1:0] i_b_data;
  logic              i_b_last;

  logic              o_vld;
  logic              i_rdy;
  logic [DWIDTH-1:0] o_data;
  logic              o_last;
  logic              o_src;
  logic              o_err;

  modport slave (
    input  i_a_vld, i_a_data, i_a_last,
    input  i_b_vld, i_b_data, i_b_last,
    input  i_rdy,
    output o_a_rdy, o_b_rdy,
    output o_vld, o_data, o_last, o_src, o_err
  );

  modport master (
    output i_a_vld, i_a_data, i_a_last,
    output i_b_vld, i_b_data, i_b_last,
    output i_rdy,
    input  o_a_rdy, o_b_rdy,
    input  o_vld, o_data, o_last, o_src, o_err
  );

endinterface

// File: rtl/cm_merge_pipe_reg.sv
// cm_pipe_reg: single-entry valid/ready register slice.
//   i_vld/o_rdy/i_data : upstream side, o_rdy = !o_vld | i_rdy
//   o_vld/i_rdy/o_data : downstream side, held while o_vld & !i_rdy
//   i_clk, i_rst       : clock, asynchronous active-high reset
module cm_pipe_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_data
);

  logic         r_vld;
  logic [W-1:0] r_data;

  // Loads when empty or when the current beat leaves this cycle.
  assign o_rdy  = !r_vld | i_rdy;
  assign o_vld  = r_vld;
  assign o_data = r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      // Payload only changes on a real load, so a drained slot keeps its value.
      if (i_vld) r_data <= i_data;
    end
  end

endmodule

// File: rtl/cm_merge.sv
// cm_merge: streaming two-way merger of two ascending streams into one
// ascending stream per frame (ties go to A).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : cm_merge_if.slave (streams A/B in, merged stream out,
//                  o_src = 0 for A / 1 for B, o_err order-violation pulse)
// Parameters: DWIDTH element width (unsigned), CHK_ORDER enables o_err.
module cm_merge
  import cm_merge_pkg::*;
#(
  parameter int DWIDTH    = CM_DWIDTH,
  parameter bit CHK_ORDER = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  cm_merge_if.slave   bus
);

  t_merge_state r_state;

  logic        w_load_en;
  logic        w_both;
  logic        w_pick_b;
  logic        w_a_rdy;
  logic        w_b_rdy;
  logic        w_a_acc;
  logic        w_b_acc;
  logic        w_out_vld;
  t_merge_beat w_beat;
  t_merge_beat w_out;

  assign w_both   = bus.i_a_vld & bus.i_b_vld;
  // Strict less-than makes equal heads pick A, keeping the merge stable.
  assign w_pick_b = bus.i_b_data < bus.i_a_data;

  always_comb begin
    w_a_rdy = 1'b0;
    w_b_rdy = 1'b0;
    w_beat  = '{data: bus.i_a_data, last: 1'b0, src: SRC_A};
    case (r_state)
      ST_MERGE: begin
        // Never emit one side without having the other head to compare.
        if (w_pick_b) begin
          w_b_rdy = w_both & w_load_en;
          w_beat  = '{data: bus.i_b_data, last: 1'b0, src: SRC_B};
        end else begin
          w_a_rdy = w_both & w_load_en;
        end
      end
      ST_DRAIN_A: begin
        w_a_rdy     = w_load_en;
        w_beat.last = bus.i_a_last;
      end
      ST_DRAIN_B: begin
        w_b_rdy = w_load_en;
        w_beat  = '{data: bus.i_b_data, last: bus.i_b_last, src: SRC_B};
      end
      default: ;
    endcase
  end

  // Ready is forced low during reset so nothing is taken from upstream
  // while the frame is being discarded.
  assign bus.o_a_rdy = w_a_rdy & !i_rst;
  assign bus.o_b_rdy = w_b_rdy & !i_rst;
  assign w_a_acc     = bus.i_a_vld & bus.o_a_rdy;
  assign w_b_acc     = bus.i_b_vld & bus.o_b_rdy;

  cm_pipe_reg #(.W(CM_BEAT_W)) u_out (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (w_a_acc | w_b_acc),
    .o_rdy  (w_load_en),
    .i_data (w_beat),
    .o_vld  (w_out_vld),
    .i_rdy  (bus.i_rdy),
    .o_data (w_out)
  );

  assign bus.o_vld  = w_out_vld;
  assign bus.o_data = w_out.data;
  assign bus.o_last = w_out.last;
  assign bus.o_src  = w_out.src;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_MERGE;
    end else begin
      case (r_state)
        ST_MERGE: begin
          if (w_a_acc && bus.i_a_last)      r_state <= ST_DRAIN_B;
          else if (w_b_acc && bus.i_b_last) r_state <= ST_DRAIN_A;
        end
        ST_DRAIN_A: if (w_a_acc && bus.i_a_last) r_state <= ST_MERGE;
        ST_DRAIN_B: if (w_b_acc && bus.i_b_last) r_state <= ST_MERGE;
        default:    r_state <= ST_MERGE;
      endcase
    end
  end

  generate
    if (CHK_ORDER) begin : g_chk
      logic [DWIDTH-1:0] r_a_prev;
      logic [DWIDTH-1:0] r_b_prev;
      logic              r_a_have;
      logic              r_b_have;
      logic              r_err;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_a_prev <= '0;
          r_b_prev <= '0;
          r_a_have <= 1'b0;
          r_b_have <= 1'b0;
          r_err    <= 1'b0;
        end else begin
          r_err <= (w_a_acc && r_a_have && (bus.i_a_data < r_a_prev)) ||
                   (w_b_acc && r_b_have && (bus.i_b_data < r_b_prev));
          // History ends with the stream's last element so frames are independent.
          if (w_a_acc) begin
            r_a_prev <= bus.i_a_data;
            r_a_have <= !bus.i_a_last;
          end
          if (w_b_acc) begin
            r_b_prev <= bus.i_b_data;
            r_b_have <= !bus.i_b_last;
          end
        end
      end

      assign bus.o_err = r_err;
    end else begin : g_no_chk
      assign bus.o_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm_merge.sv
// tb_cm_merge: directed frames against a queue-based stable-merge model.
module tb_cm_merge;

  typedef logic [8:0] el_t;  // {last, data}
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } ob_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cm_merge_if #(.DWIDTH(8)) bus();

  cm_merge #(.DWIDTH(8), .CHK_ORDER(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  el_t  a_q[$], b_q[$], fa[$], fb[$];
  ob_t  exp_q[$];
  int   log_d[$], log_s[$], log_l[$];
  int   ed[$], es[$];
  bit   rdy_tog = 1'b0;
  bit   a_fire = 1'b0, b_fire = 1'b0;
  int   cyc = 0, out_cnt = 0, first_cyc = -1, last_cyc = 0, err_cnt = 0;

  function automatic el_t e(input int d, input bit l);
    el_t r;
    r = {l, d[7:0]};
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Stable two-way merge of the staged frame: smaller head first, A on ties,
  // remainder of the surviving stream appended, last flag on the final beat.
  task automatic start_frame();
    int i = 0, j = 0;
    ob_t o;
    while (i < fa.size() || j < fb.size()) begin
      if (j >= fb.size() || (i < fa.size() && fa[i][7:0] <= fb[j][7:0])) begin
        o = '{fa[i][7:0], 1'b0, 1'b0}; i++;
      end else begin
        o = '{fb[j][7:0], 1'b0, 1'b1}; j++;
      end
      exp_q.push_back(o);
    end
    o = exp_q.pop_back();
    o.l = 1'b1;
    exp_q.push_back(o);
    foreach (fa[k]) a_q.push_back(fa[k]);
    foreach (fb[k]) b_q.push_back(fb[k]);
  endtask

  task automatic clr_log();
    log_d.delete(); log_s.delete(); log_l.delete();
    err_cnt = 0; first_cyc = -1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk({nm, "_pending_beats"}, exp_q.size(), 0);
    exp_q.delete(); a_q.delete(); b_q.delete();
    repeat (3) @(posedge clk);
  endtask

  // Literal expectation vs logged output: {data, src, last} per beat.
  task automatic cmp_log(input string nm, input int lastpos);
    chk({nm, "_count"}, log_d.size(), ed.size());
    foreach (ed[k]) if (k < log_d.size())
      chk($sformatf("%s_beat%0d", nm, k), log_d[k] * 4 + log_s[k] * 2 + log_l[k],
          ed[k] * 4 + es[k] * 2 + ((k == lastpos) ? 1 : 0));
  endtask

  // Driver: advance queues after observed acceptances, present heads.
  initial begin
    bus.i_a_vld = 1'b0; bus.i_a_data = '0; bus.i_a_last = 1'b0;
    bus.i_b_vld = 1'b0; bus.i_b_data = '0; bus.i_b_last = 1'b0;
    bus.i_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (a_fire && a_q.size() > 0) void'(a_q.pop_front());
      if (b_fire && b_q.size() > 0) void'(b_q.pop_front());
      bus.i_a_vld = a_q.size() > 0;
      if (a_q.size() > 0) begin bus.i_a_data = a_q[0][7:0]; bus.i_a_last = a_q[0][8]; end
      bus.i_b_vld = b_q.size() > 0;
      if (b_q.size() > 0) begin bus.i_b_data = b_q[0][7:0]; bus.i_b_last = b_q[0][8]; end
      bus.i_rdy = rdy_tog ? ~bus.i_rdy : 1'b1;
    end
  end

  // Compare process: output beats vs model, hold rule, o_err timing.
  initial begin
    bit   err_pend = 0, err_next, a_have = 0, b_have = 0, hold_v = 0;
    int   a_prev = 0, b_prev = 0;
    ob_t  held, o;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        a_fire = 0; b_fire = 0; err_pend = 0; a_have = 0; b_have = 0; hold_v = 0;
        continue;
      end
      chk("o_err", bus.o_err, err_pend);
      if (bus.o_err) err_cnt++;
      if (hold_v) begin
        chk("hold_vld", bus.o_vld, 1);
        chk("hold_beat", {bus.o_data, bus.o_last, bus.o_src}, held);
      end
      hold_v = bus.o_vld && !bus.i_rdy;
      held = '{bus.o_data, bus.o_last, bus.o_src};
      if (bus.o_vld && bus.i_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          o = exp_q.pop_front();
          chk("o_data", bus.o_data, o.d);
          chk("o_last", bus.o_last, o.l);
          chk("o_src", bus.o_src, o.s);
        end
        log_d.push_back(bus.o_data); log_s.push_back(bus.o_src); log_l.push_back(bus.o_last);
        out_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      a_fire = bus.i_a_vld & bus.o_a_rdy;
      b_fire = bus.i_b_vld & bus.o_b_rdy;
      err_next = 0;
      if (a_fire) begin
        if (a_have && bus.i_a_data < a_prev) err_next = 1;
        a_prev = bus.i_a_data; a_have = !bus.i_a_last;
      end
      if (b_fire) begin
        if (b_have && bus.i_b_data < b_prev) err_next = 1;
        b_prev = bus.i_b_data; b_have = !bus.i_b_last;
      end
      err_pend = err_next;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_o_vld", bus.o_vld, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_last", bus.o_last, 0);
    chk("rst_o_src", bus.o_src, 0);
    chk("rst_o_err", bus.o_err, 0);
    chk("rst_o_a_rdy", bus.o_a_rdy, 0);
    chk("rst_o_b_rdy", bus.o_b_rdy, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Basic merge; also pin the model against hand values before running.
    clr_log();
    fa = '{e(1,0), e(4,0), e(9,1)}; fb = '{e(2,0), e(3,0), e(10,1)};
    start_frame();
    ed = '{1,2,3,4,9,10}; es = '{0,1,1,0,0,1};
    chk("model_size", exp_q.size(), 6);
    foreach (ed[k]) chk($sformatf("model_beat%0d", k),
                        exp_q[k].d * 4 + exp_q[k].s * 2 + exp_q[k].l,
                        ed[k] * 4 + es[k] * 2 + ((k == 5) ? 1 : 0));
    wait_done("basic");
    cmp_log("basic", 5);
    chk("basic_span", last_cyc - first_cyc, 5);
    chk("basic_err", err_cnt, 0);

    // Ties stay stable: A beats first.
    clr_log();
    fa = '{e(5,0), e(5,1)}; fb = '{e(5,1)};
    start_frame();
    wait_done("ties");
    ed = '{5,5,5}; es = '{0,0,1};
    cmp_log("ties", 2);

    // A finishes early, downstream toggles ready.
    clr_log();
    rdy_tog = 1'b1;
    fa = '{e(7,1)}; fb = '{e(1,0), e(2,0), e(3,0), e(8,1)};
    start_frame();
    wait_done("bp");
    rdy_tog = 1'b0;
    ed = '{1,2,3,7,8}; es = '{1,1,1,0,1};
    cmp_log("bp", 4);

    // Unsorted A: one error pulse, data still forwarded.
    clr_log();
    fa = '{e(6,0), e(2,1)}; fb = '{e(9,1)};
    start_frame();
    wait_done("unsorted");
    ed = '{6,2,9}; es = '{0,0,1};
    cmp_log("unsorted", 2);
    chk("unsorted_err_pulses", err_cnt, 1);

    // Reset mid-frame after two output beats.
    clr_log();
    n = out_cnt;
    fa = '{e(1,0), e(3,0), e(5,1)}; fb = '{e(2,0), e(4,1)};
    start_frame();
    for (int i = 0; i < 100 && out_cnt < n + 2; i++) @(posedge clk);
    chk("rst_mid_outs", out_cnt - n, 2);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_in_vld", bus.i_a_vld & bus.i_b_vld, 1);
    chk("rst_mid_o_vld", bus.o_vld, 0);
    chk("rst_mid_o_a_rdy", bus.o_a_rdy, 0);
    chk("rst_mid_o_b_rdy", bus.o_b_rdy, 0);
    a_q.delete(); b_q.delete(); exp_q.delete();
    a_fire = 0; b_fire = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    clr_log();
    fa = '{e(8,1)}; fb = '{e(7,1)};
    start_frame();
    wait_done("after_rst");
    ed = '{7,8}; es = '{1,0};
    cmp_log("after_rst", 1);

    // Back-to-back frames; history restarts each frame.
    clr_log();
    fa = '{e(1,1)}; fb = '{e(2,1)};
    start_frame();
    fa = '{e(0,1)}; fb = '{e(3,1)};
    start_frame();
    wait_done("b2b");
    ed = '{1,2,0,3}; es = '{0,1,0,1};
    chk("b2b_count", log_d.size(), 4);
    foreach (ed[k]) if (k < log_d.size())
      chk($sformatf("b2b_beat%0d", k), log_d[k] * 4 + log_s[k] * 2 + log_l[k],
          ed[k] * 4 + es[k] * 2 + ((k == 1 || k == 3) ? 1 : 0));
    chk("b2b_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
